// File: rtl/reg_dump_if.sv
// Register-dump stream bundle: the reader drives the regfile read address and the dump beat.
// Start/abort and dumpReady come from the debug consumer.
interface reg_dump_if;
    logic        start;
    logic        abort;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        dumpValid;
    logic        dumpReady;
    logic [4:0]  dumpIdx;
    logic [31:0] dumpData;
    logic        dumpLast;
    logic        dumpChk;
    logic        busy;
    logic        done;

    modport master (
        input  start, abort, regData, dumpReady,
        output regAddr, dumpValid, dumpIdx, dumpData, dumpLast, dumpChk, busy, done
    );

    modport slave (
        output start, abort, regData, dumpReady,
        input  regAddr, dumpValid, dumpIdx, dumpData, dumpLast, dumpChk, busy, done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks regfile entries FIRST_REG..LAST_REG onto a valid/ready stream; DUMP_CHECKSUM_EN adds an XOR beat.
// First beat valid two edges after start; one beat per 2 cycles; outputs hold while dumpReady is low.
module reg_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic       clk,
    input  logic       rst,
    reg_dump_if.master bus
);
    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_CHK, S_FIN} state_t;
    logic [31:0] acc_q;
    logic        chk_q;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_FIN} state_t;
`endif

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [4:0]  cnt_d;
    logic [4:0]  reg_addr_q;
    logic [4:0]  idx_q;
    logic [31:0] data_q;
    logic        vld_q;
    logic        last_q;
    logic        busy_q;
    logic        done_q;
    logic        hs;

    assign cnt_d = cnt_q + 5'd1;
    assign hs    = vld_q && bus.dumpReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= FIRST_IDX;
            reg_addr_q <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc_q      <= '0;
            chk_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // Abort beats any handshake in the same cycle.
            if (bus.abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                vld_q   <= 1'b0;
                busy_q  <= 1'b0;
                cnt_q   <= FIRST_IDX;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            state_q    <= S_FETCH;
                            cnt_q      <= FIRST_IDX;
                            reg_addr_q <= FIRST_IDX;
                            busy_q     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            acc_q      <= '0;
`endif
                        end
                    end
                    S_FETCH: begin
                        data_q  <= bus.regData;
                        idx_q   <= cnt_q;
                        vld_q   <= 1'b1;
                        state_q <= S_SEND;
`ifdef DUMP_CHECKSUM_EN
                        last_q  <= 1'b0;
                        chk_q   <= 1'b0;
                        acc_q   <= acc_q ^ bus.regData;
`else
                        last_q  <= (cnt_q == LAST_IDX);
`endif
                    end
                    S_SEND: begin
                        if (hs) begin
                            if (cnt_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                                state_q <= S_CHK;
                                data_q  <= acc_q;
                                idx_q   <= LAST_IDX;
                                chk_q   <= 1'b1;
                                last_q  <= 1'b1;
`else
                                state_q <= S_FIN;
                                vld_q   <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                state_q    <= S_FETCH;
                                vld_q      <= 1'b0;
                                cnt_q      <= cnt_d;
                                reg_addr_q <= cnt_d;
                            end
                        end
                    end
`ifdef DUMP_CHECKSUM_EN
                    S_CHK: begin
                        if (hs) begin
                            state_q <= S_FIN;
                            vld_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
`endif
                    S_FIN: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.regAddr   = reg_addr_q;
    assign bus.dumpValid = vld_q;
    assign bus.dumpIdx   = idx_q;
    assign bus.dumpData  = data_q;
    assign bus.dumpLast  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef DUMP_CHECKSUM_EN
    assign bus.dumpChk   = chk_q;
`else
    assign bus.dumpChk   = 1'b0;
`endif
endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dumps, backpressure, start/abort, async reset, single-reg range.
module tb_reg_dump_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    reg_dump_if bus ();
    reg_dump_if bus1 ();
    logic [31:0] rf [32];
    assign bus.regData  = rf[bus.regAddr];
    assign bus1.regData = rf[bus1.regAddr];

    reg_dump_reader dut (.clk(clk), .rst(rst), .bus(bus));
    reg_dump_reader #(.FIRST_REG(20), .LAST_REG(20)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        chk;
    } beat_t;

    beat_t beats[$];
    int    first_vld = -1;
    int    done_cnt  = 0;
    int    done_cyc  = -1;
    int    s_cyc     = 0;
    int    n_chk     = 0;
    int    n_fail    = 0;

    always @(negedge clk) begin
        beat_t b;
        if (bus.dumpValid && bus.dumpReady) begin
            b.cyc  = cyc;
            b.idx  = bus.dumpIdx;
            b.data = bus.dumpData;
            b.last = bus.dumpLast;
            b.chk  = bus.dumpChk;
            beats.push_back(b);
        end
        if (bus.dumpValid && first_vld < 0) first_vld = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_dump();
        @(posedge clk); #1;
        beats.delete();
        first_vld = -1;
        done_cnt  = 0;
        done_cyc  = -1;
        bus.start = 1'b1;
        s_cyc     = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) break;
        end
        check_eq({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic wait_fetch(input logic [4:0] k);
        for (int i = 0; i < 200; i++) begin
            if (bus.busy && !bus.dumpValid && bus.regAddr == k) break;
            @(posedge clk); #1;
        end
        check_eq("reach_fetch", bus.regAddr, 32'(k));
    endtask

    task automatic check_dump(input string tag);
        logic [31:0] x;
        int n;
        x = '0;
        check_eq({tag, "_nbeats"}, beats.size(), NB);
        n = (beats.size() < 32) ? beats.size() : 32;
        for (int i = 0; i < n; i++) begin
            x ^= rf[i];
            check_eq({tag, "_idx"},  beats[i].idx, i);
            check_eq({tag, "_data"}, beats[i].data, rf[i]);
`ifdef DUMP_CHECKSUM_EN
            check_eq({tag, "_last"}, beats[i].last, 0);
`else
            check_eq({tag, "_last"}, beats[i].last, (i == 31) ? 1 : 0);
`endif
            check_eq({tag, "_chk"},  beats[i].chk, 0);
        end
`ifdef DUMP_CHECKSUM_EN
        if (beats.size() == 33) begin
            check_eq({tag, "_ck_idx"},  beats[32].idx, 31);
            check_eq({tag, "_ck_data"}, beats[32].data, x);
            check_eq({tag, "_ck_last"}, beats[32].last, 1);
            check_eq({tag, "_ck_chk"},  beats[32].chk, 1);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.dumpReady = 1'b1;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.dumpReady = 1'b1;
        for (int k = 0; k < 32; k++) rf[k] = k * 32'h01010101;

        // reset state
        #12;
        check_eq("rst_valid", bus.dumpValid, 0);
        check_eq("rst_busy",  bus.busy, 0);
        check_eq("rst_done",  bus.done, 0);
        check_eq("rst_addr",  bus.regAddr, 0);
        check_eq("rst_idx",   bus.dumpIdx, 0);
        check_eq("rst_data",  bus.dumpData, 0);
        check_eq("rst_last",  bus.dumpLast, 0);
        check_eq("rst_chk",   bus.dumpChk, 0);
        @(negedge clk) rst = 1'b0;

        // full dump at full rate
        start_dump();
        wait_idle("full");
        check_dump("full");
        check_eq("latency", first_vld - s_cyc, 2);
        check_eq("done_cnt", done_cnt, 1);
        if (beats.size() == NB) begin
            check_eq("span64", beats[31].cyc - s_cyc, 64);
            check_eq("done_after_hs", done_cyc, beats[NB-1].cyc + 1);
        end

        // backpressure at idx 3
        start_dump();
        wait_fetch(5'd3);
        bus.dumpReady = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", bus.dumpValid, 1);
            check_eq("stall_idx",   bus.dumpIdx, 3);
            check_eq("stall_data",  bus.dumpData, rf[3]);
            @(posedge clk); #1;
        end
        bus.dumpReady = 1'b1;
        wait_idle("stall");
        check_dump("stall");

        // start while busy ignored, abort at idx 10
        start_dump();
        wait_fetch(5'd6);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_fetch(5'd10);
        @(posedge clk); #1;
        check_eq("ab_pre_valid", bus.dumpValid, 1);
        check_eq("ab_pre_idx",   bus.dumpIdx, 10);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_eq("ab_valid", bus.dumpValid, 0);
        check_eq("ab_busy",  bus.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("ab_nodone", done_cnt, 0);
        check_eq("ab_nbeats", beats.size(), 11);
        if (beats.size() == 11) check_eq("ab_idx10", beats[10].idx, 10);
        start_dump();
        wait_idle("restart");
        check_dump("restart");

        // start and abort together in idle
        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check_eq("sa_busy", bus.busy, 0);

        // async reset mid-dump at idx 7
        start_dump();
        wait_fetch(5'd7);
        @(posedge clk); #1;
        check_eq("rm_pre_idx", bus.dumpIdx, 7);
        #2 rst = 1'b1;
        #1;
        check_eq("rm_valid", bus.dumpValid, 0);
        check_eq("rm_busy",  bus.busy, 0);
        check_eq("rm_addr",  bus.regAddr, 0);
        check_eq("rm_idx",   bus.dumpIdx, 0);
        check_eq("rm_data",  bus.dumpData, 0);
        check_eq("rm_last",  bus.dumpLast, 0);
        @(negedge clk) rst = 1'b0;
        start_dump();
        wait_idle("post_rst");
        check_dump("post_rst");

        // checksum pattern
        for (int k = 0; k < 32; k++) rf[k] = '0;
        rf[5]  = 32'h0000FFFF;
        rf[20] = 32'hDEADBEEF;
        start_dump();
        wait_idle("cksum");
        check_dump("cksum");
`ifdef DUMP_CHECKSUM_EN
        if (beats.size() == 33) check_eq("cksum_value", beats[32].data, 32'hDEAD4110);
`endif

        // single-register range
        rf[20] = 32'h12345678;
        @(posedge clk); #1;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus1.dumpValid) break;
            @(posedge clk); #1;
        end
        check_eq("one_valid", bus1.dumpValid, 1);
        check_eq("one_idx",   bus1.dumpIdx, 20);
        check_eq("one_data",  bus1.dumpData, 32'h12345678);
`ifdef DUMP_CHECKSUM_EN
        check_eq("one_last",  bus1.dumpLast, 0);
        @(posedge clk); #1;
        check_eq("one_ck_chk",  bus1.dumpChk, 1);
        check_eq("one_ck_last", bus1.dumpLast, 1);
        check_eq("one_ck_data", bus1.dumpData, 32'h12345678);
`else
        check_eq("one_last",  bus1.dumpLast, 1);
`endif
        check_eq("one_chk0",  bus1.dumpChk, 0 + bus1.dumpChk * 0 + (bus1.dumpIdx == 5'd20 && bus1.dumpLast && bus1.dumpChk ? 1 : 0));
        @(posedge clk); #1;
        check_eq("one_done",  bus1.done, 1);
        check_eq("one_vld0",  bus1.dumpValid, 0);
        @(posedge clk); #1;
        check_eq("one_done0", bus1.done, 0);
        check_eq("one_busy0", bus1.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
